// File: rtl/joy_port_scanner.sv
// Time-multiplexed scanner for up to 2**SEL_W joysticks behind one splitter, with per-port debounce.
// Optional autofire is built when the macro JOY_AUTOFIRE_EN is defined.
module joy_port_scanner #(
  parameter int SEL_W         = 1,
  parameter int NUM_BUTTONS   = 5,
  parameter int DIV_BITS      = 7,
  parameter int SETTLE_TICKS  = 2,
  parameter int DEBOUNCE      = 3,
  parameter bit SPLIT_DEFAULT = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_BUTTONS-1:0]               joy_in,
  input  logic                                 split_toggle,
`ifdef JOY_AUTOFIRE_EN
  input  logic [(2**SEL_W)-1:0]                autofire_en,
`endif
  output logic [SEL_W-1:0]                     joy_sel,
  output logic [(2**SEL_W)*NUM_BUTTONS-1:0]    joy_out,
  output logic                                 joy_valid,
  output logic                                 split_active
);

  localparam int NUM_PORTS = 2**SEL_W;
  localparam int CNT_W     = $clog2(DEBOUNCE+1);
  localparam int SET_W     = $clog2(SETTLE_TICKS+1);
  localparam logic [NUM_BUTTONS-1:0] ONES = '1;

  typedef enum logic [1:0] {
    S_SELECT = 2'd0,
    S_SAMPLE = 2'd1,
    S_NEXT   = 2'd2
  } state_t;

  logic [NUM_BUTTONS-1:0] r_sync1, r_sync2;
  logic [DIV_BITS-1:0]    r_div;
  logic                   r_tog_prev, r_split;
  state_t                 r_state;
  logic [SET_W-1:0]       r_settle;
  logic [SEL_W-1:0]       r_port;
  logic                   r_valid;

  logic                   w_tick, w_sample_stb, w_next_stb, w_scan_done;
  logic [SEL_W-1:0]       w_port_next;

  assign w_tick       = &r_div;
  assign w_sample_stb = w_tick && (r_state == S_SAMPLE);
  assign w_next_stb   = w_tick && (r_state == S_NEXT);
  // With split off every pass is a complete scan of the single active port.
  assign w_scan_done  = !r_split || (r_port == {SEL_W{1'b1}});
  assign w_port_next  = r_split ? SEL_W'(r_port + 1'b1) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= ONES;
      r_sync2 <= ONES;
      r_div   <= '0;
    end else begin
      r_sync1 <= joy_in;
      r_sync2 <= r_sync1;
      r_div   <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tog_prev <= 1'b0;
      r_split    <= SPLIT_DEFAULT;
    end else begin
      r_tog_prev <= split_toggle;
      if (split_toggle && !r_tog_prev)
        r_split <= ~r_split;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_SELECT;
      r_settle <= '0;
      r_port   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_SELECT: begin
            if (r_settle == SET_W'(SETTLE_TICKS-1)) begin
              r_settle <= '0;
              r_state  <= S_SAMPLE;
            end else begin
              r_settle <= r_settle + 1'b1;
            end
          end
          S_SAMPLE: r_state <= S_NEXT;
          S_NEXT: begin
            r_state <= S_SELECT;
            r_port  <= w_port_next;
            r_valid <= w_scan_done;
          end
          default: r_state <= S_SELECT;
        endcase
      end
    end
  end

`ifdef JOY_AUTOFIRE_EN
  logic [5:0] r_scan;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_scan <= '0;
    else if (w_next_stb && w_scan_done)
      r_scan <= r_scan + 1'b1;
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [NUM_BUTTONS-1:0] r_cand, r_out, w_masked;
      logic [CNT_W-1:0]       r_cnt;
      logic                   w_mine, w_released;

      assign w_mine     = (r_port == SEL_W'(gi));
      assign w_released = (gi != 0) && !r_split;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cand <= ONES;
          r_cnt  <= '0;
          r_out  <= ONES;
        end else begin
          if (w_sample_stb && w_mine) begin
            if (r_sync2 == r_cand) begin
              if (r_cnt != CNT_W'(DEBOUNCE))
                r_cnt <= r_cnt + 1'b1;
            end else begin
              r_cand <= r_sync2;
              r_cnt  <= CNT_W'(1);
            end
          end
          if (w_next_stb && w_mine && (r_cnt == CNT_W'(DEBOUNCE)))
            r_out <= r_cand;
          // Unused ports restart from idle so a later split-on never shows stale presses.
          if (w_released) begin
            r_cand <= ONES;
            r_cnt  <= '0;
            r_out  <= ONES;
          end
        end
      end

      assign w_masked = w_released ? ONES : r_out;

`ifdef JOY_AUTOFIRE_EN
      assign joy_out[gi*NUM_BUTTONS] =
        (autofire_en[gi] && !w_masked[0]) ? r_scan[5] : w_masked[0];
`else
      assign joy_out[gi*NUM_BUTTONS] = w_masked[0];
`endif
      assign joy_out[gi*NUM_BUTTONS+1 +: NUM_BUTTONS-1] = w_masked[NUM_BUTTONS-1:1];
    end
  endgenerate

  assign joy_sel      = r_port;
  assign joy_valid    = r_valid;
  assign split_active = r_split;

endmodule

// File: tb/tb_joy_port_scanner.sv
// Scoreboard bench for joy_port_scanner: stimulus queues expected joy_out per scan, a monitor checks each joy_valid.
// Runs the autofire sequence too when JOY_AUTOFIRE_EN is defined.
module tb_joy_port_scanner;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       split_toggle = 1'b0;
  logic [4:0] joy_in;
  logic [4:0] p0 = 5'h1F;
  logic [4:0] p1 = 5'h1F;
  logic [0:0] joy_sel;
  logic [9:0] joy_out;
  logic       joy_valid;
  logic       split_active;
`ifdef JOY_AUTOFIRE_EN
  logic [1:0] autofire_en = 2'b00;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int vcount = 0;

  typedef struct {
    logic [9:0] out;
    int         period;
    string      tag;
  } exp_t;
  exp_t exp_q[$];

  logic [4:0] g_drv [9] = '{5'h1F, 5'h1F, 5'h1F, 5'h1E, 5'h1F, 5'h1F, 5'h1E, 5'h1E, 5'h1E};
  logic [9:0] g_exp [9] = '{10'h37E, 10'h37E, 10'h37F, 10'h37F, 10'h37F, 10'h37F, 10'h37F, 10'h37F, 10'h37E};

  // Splitter model: the board inputs show whichever port is selected.
  assign joy_in = (joy_sel == 1'b0) ? p0 : p1;

  joy_port_scanner #(
    .SEL_W(1), .NUM_BUTTONS(5), .DIV_BITS(2), .SETTLE_TICKS(2), .DEBOUNCE(3), .SPLIT_DEFAULT(1'b0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .joy_in(joy_in),
    .split_toggle(split_toggle),
`ifdef JOY_AUTOFIRE_EN
    .autofire_en(autofire_en),
`endif
    .joy_sel(joy_sel),
    .joy_out(joy_out),
    .joy_valid(joy_valid),
    .split_active(split_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [9:0] o, input int per, input string tag);
    exp_q.push_back('{out: o, period: per, tag: tag});
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!joy_valid && n < 300);
    if (!joy_valid) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no joy_valid within %0d clk", tag, n);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s drain: %0d expected scans never arrived", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every joy_valid pops one expectation (if any) and checks output, scan period and select.
  initial begin
    exp_t it;
    int   d;
    forever begin
      @(negedge clk);
      if (reset_n && joy_valid) begin
        d        = cyc - last_cyc;
        last_cyc = cyc;
        vcount++;
        if (exp_q.size() > 0) begin
          it = exp_q.pop_front();
          chk({it.tag, " joy_out"}, 32'(joy_out), 32'(it.out));
          if (it.period != 0)
            chk({it.tag, " period"}, d, it.period);
          chk({it.tag, " joy_sel"}, 32'(joy_sel), 32'd0);
          $display("scan %-9s joy_out=%h period=%0d", it.tag, joy_out, d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rst_base;
    int base;
    logic b;

    // Reset and idle: all released, one port-0 pass every 16 clk.
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst joy_out", 32'(joy_out), 32'h3FF);
    chk("rst joy_sel", 32'(joy_sel), 32'd0);
    chk("rst joy_valid", 32'(joy_valid), 32'd0);
    chk("rst split", 32'(split_active), 32'd0);
    push(10'h3FF, 0, "idle");
    for (int i = 0; i < 3; i++) push(10'h3FF, 16, "idle");
    reset_n = 1'b1;
    drain("idle");

    // Split on with distinct presses per port.
    wait_valid("split sync");
    #1;
    p0 = 5'h1E;
    p1 = 5'h1B;
    split_toggle = 1'b1;
    push(10'h3FF, 32, "split");
    push(10'h3FF, 32, "split");
    push(10'h37E, 32, "split");
    push(10'h37E, 32, "split");
    @(posedge clk);
    #1;
    chk("split on", 32'(split_active), 32'd1);
    split_toggle = 1'b0;
    drain("split");

    // Port-0 glitch rejection then a real change after three scans.
    wait_valid("glitch sync");
    #1;
    for (int i = 0; i < 9; i++) push(g_exp[i], 32, "glitch");
    for (int i = 0; i < 9; i++) begin
      p0 = g_drv[i];
      wait_valid("glitch");
      #1;
    end
    drain("glitch");

    // Split off in the middle of port 1's settle: release is immediate, the scan is not cut short.
    wait_valid("release sync");
    #1;
    push(10'h3FE, 32, "release");
    push(10'h3FE, 16, "release");
    push(10'h3FE, 16, "release");
    repeat (19) @(negedge clk);
    split_toggle = 1'b1;
    @(posedge clk);
    #1;
    chk("split off", 32'(split_active), 32'd0);
    chk("released joy_out", 32'(joy_out), 32'h3FE);
    chk("sel kept during port1", 32'(joy_sel), 32'd1);
    split_toggle = 1'b0;
    wait_valid("release");
    #1;
    repeat (20) @(negedge clk);
    chk("sel after release", 32'(joy_sel), 32'd0);
    drain("release");

    // Reset asserted while port 1 is being sampled.
    wait_valid("reset sync");
    #1;
    split_toggle = 1'b1;
    @(posedge clk);
    #1;
    split_toggle = 1'b0;
    chk("split on again", 32'(split_active), 32'd1);
    repeat (25) @(negedge clk);
    chk("pre-reset sel", 32'(joy_sel), 32'd1);
    push(10'h3FF, 0, "postrst");
    push(10'h3FF, 16, "postrst");
    push(10'h3FE, 16, "postrst");
    reset_n = 1'b0;
    #1;
    chk("async rst joy_out", 32'(joy_out), 32'h3FF);
    chk("async rst joy_sel", 32'(joy_sel), 32'd0);
    chk("async rst joy_valid", 32'(joy_valid), 32'd0);
    chk("async rst split", 32'(split_active), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rst_base = vcount;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!joy_valid && n < 100);
    chk("first valid after reset", n, 16);
    drain("postrst");

`ifdef JOY_AUTOFIRE_EN
    // Autofire on port 0 with fire held: bit0 follows bit5 of the scan count, then fire is released.
    wait_valid("autofire sync");
    #1;
    base = vcount - rst_base;
    autofire_en = 2'b01;
    for (int k = 1; k <= 75; k++) begin
      n = base + k;
      b = (k <= 72) ? n[5] : 1'b1;
      push({5'h1F, 4'hF, b}, 16, "autofire");
    end
    repeat (70) wait_valid("autofire");
    #1;
    p0 = 5'h1F;
    drain("autofire");
`else
    base = 0;
    b = 1'b0;
    if (base != 0 || b != 1'b0) $display("unexpected state");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
